uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_arb_if.sv | 24 ++
 rtl/uart_rr_pick.sv | 33 +++
 rtl/uart_tx_arb.sv | 87 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package uart_pkg;

  localparam int unsigned FrameCyclesDefault = 52080;
  localparam int unsigned ByteW              = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Request/accept handshakes for two byte sources plus the strobe/data pair to the UART.
interface uart_tx_arb_if;

  logic                       req0_valid;
  logic                       req1_valid;
  logic [uart_pkg::ByteW-1:0] req0_data;
  logic [uart_pkg::ByteW-1:0] req1_data;
  logic                       req0_ready;
  logic                       req1_ready;
  logic                       uart_write;
  logic [uart_pkg::ByteW-1:0] uart_data;
  logic                       busy;

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data,
    input  req0_ready, req1_ready, uart_write, uart_data, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data,
    output req0_ready, req1_ready, uart_write, uart_data, busy
  );

endinterface

// File: rtl/uart_rr_pick.sv
// One-hot grant between two requesters; round-robin by default, fixed priority
// (req0 first) when UART_ARB_FIXED_PRIO_EN is defined.
module uart_rr_pick (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,    // index of the requester granted last
  output logic [1:0] grant_o
);

`ifdef UART_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ptr_i;

  always_comb begin
    grant_o = 2'b00;
    if (valid_i[0]) begin
      grant_o = 2'b01;
    end else if (valid_i[1]) begin
      grant_o = 2'b10;
    end
  end
`else
  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates two byte sources onto one UART transmitter, reserving FRAME_CYCLES per byte.
// Build with UART_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FrameCyclesDefault
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_arb_if.slave  bus
);

  arb_state_e       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [ByteW-1:0] byte_q, byte_d;
  logic [1:0]       grant;
  logic             accept;

`ifdef UART_ARB_FIXED_PRIO_EN
  logic ptr_q;
  assign ptr_q = 1'b1;
`else
  logic ptr_q, ptr_d;
  assign ptr_d = accept ? grant[1] : ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  uart_rr_pick u_pick (
    .valid_i ({bus.req1_valid, bus.req0_valid}),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // Ready is gated by reset so it drops the instant reset is asserted.
  assign accept         = (state_q == StIdle) && (|grant) && reset;
  assign bus.req0_ready = accept && grant[0];
  assign bus.req1_ready = accept && grant[1];
  assign bus.uart_write = (state_q == StLoad);
  assign bus.uart_data  = (state_q == StLoad) ? byte_q : '0;
  assign bus.busy       = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          byte_d  = grant[1] ? bus.req1_data : bus.req0_data;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = 16'(FRAME_CYCLES - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 16'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
    end
  end

endmodule
